// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: dumper state enum, stream kind codes, counter width and index-width helper
package cpu_dbg_pkg;
  typedef enum logic [2:0] {RUN, HDR, REGS, MEMS, HALT} dump_state_e;
  localparam logic [1:0] DUMP_KIND_HDR = 2'd0;
  localparam logic [1:0] DUMP_KIND_REG = 2'd1;
  localparam logic [1:0] DUMP_KIND_MEM = 2'd2;
  localparam int CNT_W = 32;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dump_trigger.sv
// dump_trigger: run/period counters, pending request, final detect (in: clk_i rst_i trig_i run_i; out: start_o final_o run_cnt_o)
module dump_trigger
  import cpu_dbg_pkg::*;
#(
  parameter int PERIOD = 1,
  parameter int MAX_CYCLES = 20
)(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             trig_i,
  input  logic             run_i,
  output logic             start_o,
  output logic             final_o,
  output logic [CNT_W-1:0] run_cnt_o
);
  logic [CNT_W-1:0] per_cnt;
  logic pend, per_hit, fin_hit;
  always_comb begin
    per_hit = (PERIOD != 0) && (per_cnt == CNT_W'(PERIOD - 1));
    fin_hit = (MAX_CYCLES != 0) && (run_cnt_o == CNT_W'(MAX_CYCLES - 1));
    start_o = run_i && (trig_i || pend || per_hit || fin_hit);
    final_o = run_i && fin_hit;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_cnt_o <= '0;
      per_cnt <= '0;
      pend <= 1'b0;
    end else begin
      run_cnt_o <= run_i ? run_cnt_o + CNT_W'(1) : run_cnt_o;
      per_cnt <= start_o ? '0 : run_i ? per_cnt + CNT_W'(1) : per_cnt;
      pend <= start_o ? 1'b0 : (trig_i && !run_i) ? 1'b1 : pend;
    end
  end
endmodule

// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper: freezes the core and streams header, register file and memory words over valid/ready
module cpu_state_dumper
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter int MEM_WORDS = 32,
  parameter int MEM_W = 8,
  parameter int PERIOD = 1,
  parameter int MAX_CYCLES = 20,
  localparam int RAW = idx_w(NUM_REGS),
  localparam int MAW = idx_w(MEM_WORDS),
  localparam int IW = (RAW > MAW) ? RAW : MAW
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trig_i,
  output logic              hold_o,
  output logic [RAW-1:0]    reg_addr_o,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [MAW-1:0]    mem_addr_o,
  input  logic [MEM_W-1:0]  mem_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [1:0]        dump_kind_o,
  output logic [IW-1:0]     dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              done_o
);
  dump_state_e state_q, state_n;
  logic [IW-1:0] idx_q, idx_n;
  logic [CNT_W-1:0] run_cnt, hdr_q, hdr_n;
  logic fin_q, fin_n, start, final_req, beat, reg_last, mem_last;
  logic hold_n, valid_n, done_n;
  logic [1:0] kind_n;
  dump_trigger #(.PERIOD(PERIOD), .MAX_CYCLES(MAX_CYCLES)) u_trig (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .trig_i(trig_i),
    .run_i(state_q == RUN),
    .start_o(start),
    .final_o(final_req),
    .run_cnt_o(run_cnt)
  );
  always_comb begin
    beat = dump_valid_o && dump_ready_i;
    reg_last = idx_q == IW'(NUM_REGS - 1);
    mem_last = idx_q == IW'(MEM_WORDS - 1);
    state_n = state_q;
    idx_n = idx_q;
    fin_n = fin_q;
    hdr_n = hdr_q;
    unique case (state_q)
      RUN: if (start) begin
        state_n = HDR;
        idx_n = '0;
        fin_n = final_req;
        hdr_n = run_cnt;
      end
      HDR: if (beat) state_n = REGS;
      REGS: if (beat) begin
        state_n = reg_last ? MEMS : REGS;
        idx_n = reg_last ? '0 : idx_q + IW'(1);
      end
      MEMS: if (beat) begin
        state_n = mem_last ? (fin_q ? HALT : RUN) : MEMS;
        idx_n = mem_last ? '0 : idx_q + IW'(1);
      end
      default: ;
    endcase
    hold_n = state_n != RUN;
    valid_n = state_n inside {HDR, REGS, MEMS};
    done_n = state_n == HALT;
    kind_n = (state_n == REGS) ? DUMP_KIND_REG : (state_n == MEMS) ? DUMP_KIND_MEM : DUMP_KIND_HDR;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      idx_q <= '0;
      fin_q <= 1'b0;
      hdr_q <= '0;
      hold_o <= 1'b0;
      dump_valid_o <= 1'b0;
      done_o <= 1'b0;
      dump_kind_o <= DUMP_KIND_HDR;
    end else begin
      state_q <= state_n;
      idx_q <= idx_n;
      fin_q <= fin_n;
      hdr_q <= hdr_n;
      hold_o <= hold_n;
      dump_valid_o <= valid_n;
      done_o <= done_n;
      dump_kind_o <= kind_n;
    end
  end
  assign dump_idx_o = idx_q;
  assign reg_addr_o = (state_q == REGS) ? idx_q[RAW-1:0] : '0;
  assign mem_addr_o = (state_q == MEMS) ? idx_q[MAW-1:0] : '0;
  assign dump_data_o = (state_q == HDR) ? DATA_W'(hdr_q) :
                       (state_q == REGS) ? reg_data_i :
                       (state_q == MEMS) ? DATA_W'(mem_data_i) : '0;
endmodule
